// File: rtl/countdown_pkg.sv
// Shared definitions for the countdown timer slice.
//   state_t   : top-level FSM states
//   SEP       : separator nibble placed between hh/mm/ss in the display word
//   *_MAX     : highest legal value of each fixed-radix BCD digit
//   digit_max : per-digit wrap limit, digit index 0=sec1 .. 5=hr10
package countdown_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE,
    ST_DONE
  } state_t;

  localparam logic [3:0] SEP       = 4'hF;
  localparam logic [3:0] SEC1_MAX  = 4'd9;
  localparam logic [3:0] SEC10_MAX = 4'd5;
  localparam logic [3:0] MIN1_MAX  = 4'd9;
  localparam logic [3:0] MIN10_MAX = 4'd5;
  localparam logic [3:0] HR1_MAX   = 4'd9;

  function automatic logic [3:0] digit_max(input logic [2:0] idx,
                                           input logic [3:0] hr10_max);
    logic [3:0] m;
    case (idx)
      3'd0:    m = SEC1_MAX;
      3'd1:    m = SEC10_MAX;
      3'd2:    m = MIN1_MAX;
      3'd3:    m = MIN10_MAX;
      3'd4:    m = HR1_MAX;
      default: m = hr10_max;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/countdown_core_btn_qualify.sv
// Button press qualifier with optional auto-repeat.
//   clk, rst : system clock, asynchronous active-high reset
//   level    : raw button level
//   pulse    : one-cycle event when the held count reaches PRESS_CYC, then
//              (REPEAT_EN=1 only) every REPEAT_CYC cycles while still held
module btn_qualify #(
  parameter int unsigned PRESS_CYC  = 2_500_000,
  parameter int unsigned REPEAT_CYC = 25_000_000,
  parameter bit          REPEAT_EN  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic pulse
);

  localparam int unsigned MAXC = (PRESS_CYC > REPEAT_CYC) ? PRESS_CYC : REPEAT_CYC;
  localparam int unsigned W    = $clog2(MAXC + 1);

  // cnt counts toward the first press while !qual, then reuses itself as the
  // repeat-period counter once the press has qualified.
  logic [W-1:0] cnt;
  logic         qual;
  logic         press_hit;
  logic         repeat_hit;

  assign press_hit  = !qual && (cnt == W'(PRESS_CYC - 1));
  assign repeat_hit = qual && REPEAT_EN && (cnt == W'(REPEAT_CYC - 1));
  assign pulse      = level && (press_hit || repeat_hit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      qual <= 1'b0;
    end else if (!level) begin
      cnt  <= '0;
      qual <= 1'b0;
    end else if (press_hit) begin
      cnt  <= '0;
      qual <= 1'b1;
    end else if (repeat_hit) begin
      cnt  <= '0;
    end else if (!qual || REPEAT_EN) begin
      cnt  <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/countdown_core.sv
// HH:MM:SS countdown timer with button-driven digit editing.
//   clk, rst                         : clock, asynchronous active-high reset
//   up, down, left, right, start     : raw button levels
//   modify, mode                     : editing allowed when modify=1 and mode==MODE_ID
//   disp    : {hr10,hr1,F,min10,min1,F,sec10,sec1} BCD display word
//   cursor  : edited digit index 0=sec1 .. 5=hr10
//   running : high in RUN; done: one-cycle expiry pulse; blink: DONE flasher
module countdown_core
  import countdown_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 100_000_000,
  parameter int unsigned PRESS_CYC  = 2_500_000,
  parameter int unsigned REPEAT_CYC = 25_000_000,
  parameter int unsigned HR10_MAX   = 9,
  parameter int unsigned MODE_ID    = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        up,
  input  logic        down,
  input  logic        left,
  input  logic        right,
  input  logic        start,
  input  logic        modify,
  input  logic [3:0]  mode,
  output logic [31:0] disp,
  output logic [2:0]  cursor,
  output logic        running,
  output logic        done,
  output logic        blink
);

  localparam int unsigned PW = $clog2(TICK_DIV + 1);

  state_t           state;
  logic [5:0][3:0]  dig;
  logic [5:0][3:0]  preset;
  logic [PW-1:0]    presc;

  logic ev_up, ev_down, ev_left, ev_right, ev_start;

  btn_qualify #(.PRESS_CYC(PRESS_CYC), .REPEAT_CYC(REPEAT_CYC), .REPEAT_EN(1'b1))
    u_up    (.clk(clk), .rst(rst), .level(up),    .pulse(ev_up));
  btn_qualify #(.PRESS_CYC(PRESS_CYC), .REPEAT_CYC(REPEAT_CYC), .REPEAT_EN(1'b1))
    u_down  (.clk(clk), .rst(rst), .level(down),  .pulse(ev_down));
  btn_qualify #(.PRESS_CYC(PRESS_CYC), .REPEAT_CYC(REPEAT_CYC), .REPEAT_EN(1'b0))
    u_left  (.clk(clk), .rst(rst), .level(left),  .pulse(ev_left));
  btn_qualify #(.PRESS_CYC(PRESS_CYC), .REPEAT_CYC(REPEAT_CYC), .REPEAT_EN(1'b0))
    u_right (.clk(clk), .rst(rst), .level(right), .pulse(ev_right));
  btn_qualify #(.PRESS_CYC(PRESS_CYC), .REPEAT_CYC(REPEAT_CYC), .REPEAT_EN(1'b0))
    u_start (.clk(clk), .rst(rst), .level(start), .pulse(ev_start));

  // Opposing events in the same cycle cancel out.
  logic inc, dec, mv_left, mv_right;
  assign inc      = ev_up   && !ev_down;
  assign dec      = ev_down && !ev_up;
  assign mv_left  = ev_left  && !ev_right;
  assign mv_right = ev_right && !ev_left;

  logic edit_en, nonzero, tick;
  assign edit_en = modify && (mode == 4'(MODE_ID));
  assign nonzero = |dig;
  assign tick    = (presc == PW'(TICK_DIV - 1));

  assign disp = {dig[5], dig[4], SEP, dig[3], dig[2], SEP, dig[1], dig[0]};

  // Next value of the digit under the cursor after an up/down event.
  logic [3:0] cur_max, cur_dig, cur_next;
  always_comb begin
    cur_max  = digit_max(cursor, 4'(HR10_MAX));
    cur_dig  = dig[cursor];
    cur_next = cur_dig;
    if (inc)
      cur_next = (cur_dig >= cur_max) ? '0 : cur_dig + 4'd1;
    else if (dec)
      cur_next = (cur_dig == '0) ? cur_max : cur_dig - 4'd1;
  end

  // One-second BCD decrement; a digit at zero wraps to its radix max and
  // borrows from the next. hr10 never borrows since RUN implies nonzero.
  logic [5:0][3:0] dec_val;
  logic            borrow;
  logic            dec_zero;
  always_comb begin
    dec_val = dig;
    borrow  = 1'b1;
    for (int unsigned i = 0; i < 6; i++) begin
      if (borrow) begin
        if (dig[i] == '0) begin
          dec_val[i] = digit_max(3'(i), 4'(HR10_MAX));
        end else begin
          dec_val[i] = dig[i] - 4'd1;
          borrow     = 1'b0;
        end
      end
    end
    dec_zero = (dec_val == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      dig     <= '0;
      preset  <= '0;
      cursor  <= '0;
      presc   <= '0;
      running <= 1'b0;
      done    <= 1'b0;
      blink   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ev_start && nonzero) begin
            preset  <= dig;
            presc   <= '0;
            state   <= ST_RUN;
            running <= 1'b1;
          end else if (edit_en) begin
            // Digit change applies at the pre-move cursor position.
            dig[cursor] <= cur_next;
            if (mv_left)
              cursor <= (cursor == 3'd5) ? '0 : cursor + 3'd1;
            else if (mv_right)
              cursor <= (cursor == '0) ? 3'd5 : cursor - 3'd1;
          end
        end
        ST_RUN: begin
          if (ev_start) begin
            state   <= ST_PAUSE;
            running <= 1'b0;
          end else if (tick) begin
            presc <= '0;
            dig   <= dec_val;
            if (dec_zero) begin
              state   <= ST_DONE;
              running <= 1'b0;
              done    <= 1'b1;
            end
          end else begin
            presc <= presc + 1'b1;
          end
        end
        ST_PAUSE: begin
          if (ev_start) begin
            state   <= ST_RUN;
            running <= 1'b1;
          end
        end
        ST_DONE: begin
          if (ev_start) begin
            dig   <= preset;
            blink <= 1'b0;
            state <= ST_IDLE;
          end else if (tick) begin
            presc <= '0;
            blink <= !blink;
          end else begin
            presc <= presc + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_countdown_core.sv
// Self-checking bench for countdown_core: a seconds-based behavioural model
// checked every cycle, directed scenarios with literal expectations, then
// randomized button activity.
module tb_countdown_core;

  localparam int TICK = 10;
  localparam int PRESS = 3;
  localparam int REP = 5;
  localparam int HR10M = 9;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0, start = 1'b0;
  logic        modify = 1'b0;
  logic [3:0]  mode = 4'd0;
  logic [31:0] disp;
  logic [2:0]  cursor;
  logic        running, done, blink;

  int n_checks = 0;
  int n_err = 0;

  countdown_core #(
    .TICK_DIV(TICK), .PRESS_CYC(PRESS), .REPEAT_CYC(REP),
    .HR10_MAX(HR10M), .MODE_ID(7)
  ) dut (
    .clk(clk), .rst(rst), .up(up), .down(down), .left(left), .right(right),
    .start(start), .modify(modify), .mode(mode), .disp(disp), .cursor(cursor),
    .running(running), .done(done), .blink(blink)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int PH_IDLE = 0, PH_RUN = 1, PH_PAUSE = 2, PH_DONE = 3;
  int m_held[5];
  int m_dig[6];
  int m_pre[6];
  int m_cur, m_phase, m_presc;
  bit m_done, m_blink;

  function automatic int dmax(input int i);
    int t[6] = '{9, 5, 9, 5, 9, HR10M};
    return t[i];
  endfunction

  function automatic int total_secs();
    return (m_dig[5] * 10 + m_dig[4]) * 3600 + (m_dig[3] * 10 + m_dig[2]) * 60
           + m_dig[1] * 10 + m_dig[0];
  endfunction

  task automatic set_secs(input int t);
    int h, m, s;
    h = t / 3600; m = (t % 3600) / 60; s = t % 60;
    m_dig[5] = h / 10; m_dig[4] = h % 10;
    m_dig[3] = m / 10; m_dig[2] = m % 10;
    m_dig[1] = s / 10; m_dig[0] = s % 10;
  endtask

  function automatic logic [31:0] m_disp();
    return {4'(m_dig[5]), 4'(m_dig[4]), 4'hF, 4'(m_dig[3]), 4'(m_dig[2]), 4'hF,
            4'(m_dig[1]), 4'(m_dig[0])};
  endfunction

  task automatic model_step();
    bit lv[5];
    bit ev[5];
    bit inc, dec, ml, mr;
    m_done = 1'b0;
    if (rst) begin
      for (int i = 0; i < 5; i++) m_held[i] = 0;
      for (int i = 0; i < 6; i++) begin m_dig[i] = 0; m_pre[i] = 0; end
      m_cur = 0; m_phase = PH_IDLE; m_presc = 0; m_blink = 1'b0;
      return;
    end
    lv = '{up, down, left, right, start};
    for (int i = 0; i < 5; i++) begin
      m_held[i] = lv[i] ? m_held[i] + 1 : 0;
      ev[i] = (m_held[i] == PRESS) ||
              (i < 2 && m_held[i] > PRESS && (m_held[i] - PRESS) % REP == 0);
    end
    inc = ev[0] && !ev[1]; dec = ev[1] && !ev[0];
    ml  = ev[2] && !ev[3]; mr  = ev[3] && !ev[2];
    case (m_phase)
      PH_IDLE: begin
        if (ev[4] && total_secs() != 0) begin
          m_pre = m_dig; m_presc = 0; m_phase = PH_RUN;
        end else if (modify && mode == 4'd7) begin
          if (inc) m_dig[m_cur] = (m_dig[m_cur] + 1) % (dmax(m_cur) + 1);
          else if (dec) m_dig[m_cur] = (m_dig[m_cur] + dmax(m_cur)) % (dmax(m_cur) + 1);
          if (ml) m_cur = (m_cur + 1) % 6;
          else if (mr) m_cur = (m_cur + 5) % 6;
        end
      end
      PH_RUN: begin
        if (ev[4]) m_phase = PH_PAUSE;
        else if (m_presc == TICK - 1) begin
          m_presc = 0;
          set_secs(total_secs() - 1);
          if (total_secs() == 0) begin m_phase = PH_DONE; m_done = 1'b1; end
        end else m_presc++;
      end
      PH_PAUSE: if (ev[4]) m_phase = PH_RUN;
      default: begin
        if (ev[4]) begin m_dig = m_pre; m_blink = 1'b0; m_phase = PH_IDLE; end
        else if (m_presc == TICK - 1) begin m_presc = 0; m_blink = !m_blink; end
        else m_presc++;
      end
    endcase
  endtask

  // Single compare process: model advances on each edge, DUT checked 1 later.
  always @(posedge clk) begin
    model_step();
    #1;
    chk("disp", disp, m_disp());
    chk("cursor", 32'(cursor), 32'(m_cur));
    chk("running", 32'(running), 32'(m_phase == PH_RUN));
    chk("done", 32'(done), 32'(m_done));
    chk("blink", 32'(blink), 32'(m_blink));
  end

  // ---------------- stimulus ----------------
  task automatic set_btn(input int idx, input logic v);
    case (idx)
      0: up = v;
      1: down = v;
      2: left = v;
      3: right = v;
      default: start = v;
    endcase
  endtask

  task automatic press(input int idx, input int n);
    set_btn(idx, 1'b1);
    repeat (n) @(negedge clk);
    set_btn(idx, 1'b0);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  int done_cnt, tog, rem[5];
  logic prev_blink;

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_disp", disp, 32'h00F00F00);
    chk("reset_flags", {29'd0, running, done, blink}, 32'd0);
    rst = 1'b0;
    mode = 4'd7; modify = 1'b1;
    @(negedge clk);

    // first press then auto-repeat
    up = 1'b1;
    repeat (3) @(negedge clk);
    chk("sec1_first", disp, 32'h00F00F01);
    repeat (8) @(negedge clk);
    up = 1'b0;
    chk("sec1_repeat", disp, 32'h00F00F02);
    @(negedge clk);

    // cursor wrap, hr10 wrap, cancellation
    press(3, 3);
    chk("cursor_wrap", 32'(cursor), 32'd5);
    repeat (9) press(0, 3);
    chk("hr10_nine", disp, 32'h90F00F02);
    press(0, 3);
    chk("hr10_wrap", disp, 32'h00F00F02);
    up = 1'b1; down = 1'b1;
    repeat (3) @(negedge clk);
    up = 1'b0; down = 1'b0;
    @(negedge clk);
    chk("updown_cancel", disp, 32'h00F00F02);
    press(2, 3);
    chk("cursor_left_wrap", 32'(cursor), 32'd0);

    // set 00:01:00, run, borrow, pause
    press(1, 3); press(1, 3);
    press(2, 3); press(2, 3);
    press(0, 3);
    chk("set_1min", disp, 32'h00F01F00);
    press(4, 3);
    chk("running", 32'(running), 32'd1);
    repeat (9) @(negedge clk);
    chk("borrow_59", disp, 32'h00F00F59);
    press(4, 3);
    repeat (20) @(negedge clk);
    chk("pause_frozen", disp, 32'h00F00F59);
    chk("pause_not_running", 32'(running), 32'd0);
    press(4, 3);
    chk("resume", 32'(running), 32'd1);

    // expiry, blink, reload
    do_reset();
    press(0, 3); press(0, 3);
    press(4, 3);
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk("done_pulses", 32'(done_cnt), 32'd1);
    chk("done_disp", disp, 32'h00F00F00);
    prev_blink = blink; tog = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (blink != prev_blink) tog++;
      prev_blink = blink;
    end
    chk("blink_toggles", 32'(tog), 32'd2);
    press(4, 3);
    chk("reload_disp", disp, 32'h00F00F02);
    chk("reload_flags", {29'd0, running, done, blink}, 32'd0);

    // zero start ignored, reset mid-run
    do_reset();
    press(4, 3);
    chk("zero_start", 32'(running), 32'd0);
    press(0, 3);
    press(4, 3);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_rst_disp", disp, 32'h00F00F00);
    chk("async_rst_flags", {29'd0, running, done, blink}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk("no_done_after_rst", 32'(done_cnt), 32'd0);

    // randomized activity
    for (int i = 0; i < 5; i++) rem[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (c % 700 == 699) rst = 1'b1;
      else rst = 1'b0;
      for (int b = 0; b < 5; b++) begin
        if (rem[b] > 0) rem[b]--;
        else if ($urandom_range(0, (b == 4) ? 40 : 7) == 0) rem[b] = $urandom_range(1, 14);
        set_btn(b, rem[b] > 0);
      end
      modify = ($urandom_range(0, 9) != 0);
      mode = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'd7;
    end
    for (int b = 0; b < 5; b++) set_btn(b, 1'b0);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/countdown_core.md
COUNTDOWN_CORE -- requirements
Module: countdown_core

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100_000_000, clk cycles per one-second tick.
REQ-002 SHALL have parameter PRESS_CYC, default 2_500_000, consecutive held cycles that qualify a button press.
REQ-003 SHALL have parameter REPEAT_CYC, default 25_000_000, auto-repeat period for held up/down after qualification.
REQ-004 SHALL have parameter HR10_MAX, default 9, maximum hour-tens digit.
REQ-005 SHALL have parameter MODE_ID, default 7, mode value that enables editing.
REQ-006 SHALL have port clk, input, 1, single system clock, all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-008 SHALL have ports up, down, left, right, start, input, 1 each, raw level buttons.
REQ-009 SHALL have port modify, input, 1, edit enable; port mode, input, 4, selected display mode.
REQ-010 SHALL have port disp, output, 32, {hr10,hr1,4'hF,min10,min1,4'hF,sec10,sec1} BCD.
REQ-011 SHALL have port cursor, output, 3, edited digit index 0=sec1 .. 5=hr10.
REQ-012 SHALL have ports running, done, blink, output, 1 each: RUN state, one-cycle expiry pulse, DONE flasher.

Function
REQ-013 Each button SHALL produce a one-cycle event when its held count reaches PRESS_CYC; count clears when released.
REQ-014 Held up/down SHALL additionally emit an event every REPEAT_CYC cycles after the first; left/right/start SHALL not repeat.
REQ-015 up and down events in the same cycle SHALL cancel (no change); likewise left and right.
REQ-016 FSM states SHALL be IDLE, RUN, PAUSE, DONE.
REQ-017 Digit editing SHALL occur only in IDLE with modify=1 and mode==MODE_ID.
REQ-018 left SHALL move cursor +1 with 5->0 wrap; right SHALL move cursor -1 with 0->5 wrap.
REQ-019 up/down SHALL inc/dec the cursor digit with wrap: sec1/min1/hr1 0..9, sec10/min10 0..5, hr10 0..HR10_MAX.
REQ-020 start in IDLE SHALL, if value nonzero, save value to preset register, clear tick prescaler, enter RUN next cycle; if zero, be ignored.
REQ-021 start in RUN SHALL enter PAUSE, prescaler frozen; start in PAUSE SHALL resume RUN from frozen prescaler.
REQ-022 In RUN, prescaler reaching TICK_DIV-1 SHALL wrap to 0 and decrement value by one second with BCD borrow (00:01:00 -> 00:00:59, 01:00:00 -> 00:59:59).
REQ-023 Decrement producing 00:00:00 SHALL enter DONE and pulse done for exactly that cycle.
REQ-024 In DONE, blink SHALL toggle on every tick; start SHALL reload preset into value and enter IDLE with blink=0.
REQ-025 running SHALL be 1 exactly in RUN; cursor SHALL hold its value outside IDLE.
REQ-026 Editing inputs in RUN/PAUSE/DONE SHALL be ignored; mode/modify changes SHALL not affect running countdown.

Reset
REQ-027 rst SHALL asynchronously force IDLE, all digits and preset 0, cursor 0, prescaler and button counters 0.
REQ-028 During reset, disp SHALL read 32'h00F00F00; running, done, blink SHALL be 0.
REQ-029 rst asserted mid-RUN SHALL abandon the count with no done pulse.

Structure
REQ-030 Package countdown_pkg SHALL hold the state enum, per-digit max constants, separator nibble 4'hF.
REQ-031 Sub-module btn_qualify (params PRESS_CYC, REPEAT_CYC, REPEAT_EN) SHALL be instantiated once per button.

Verification (bench params TICK_DIV=10, PRESS_CYC=3, REPEAT_CYC=5)
REQ-032 Reset, then mode=7, modify=1, up held 3 cycles -> sec1=1; held 8 more cycles -> sec1=2 at repeat, disp 32'h00F00F02.
REQ-033 right from cursor 0 -> cursor 5; up 10x at hr10 with HR10_MAX=9 -> hr10 wraps 9->0; up+down together -> no change.
REQ-034 Set 00:01:00, start -> running=1; after 10 cycles disp 32'h00F00F59; start -> PAUSE, value frozen 20 cycles.
REQ-035 Set 00:00:02, start -> after 20 cycles done pulses one cycle, DONE, blink toggles per tick; start -> IDLE, disp 32'h00F00F02.
REQ-036 start with value 0 -> stays IDLE; rst asserted mid-RUN -> IDLE, disp 32'h00F00F00, no done pulse.
